// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch and sequencing block with next-PC logic and fetch timeout
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic        instrValid,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        hold,
  output logic [31:0] pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // PC is word aligned; the low two bits of the reset vector are dropped.
  localparam logic [31:0] PC_INIT    = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_wait;
  logic        r_fault;

  logic        w_load_instr;
  logic        w_load_pc;
  logic        w_wait_clr;
  logic        w_wait_step;
  logic        w_set_fault;
  logic [7:0]  w_wait_inc;
  logic        w_timeout;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_pc_next;

  // Wait counter never exceeds MAX_WAIT-1 while fetching, so the increment cannot wrap.
  assign w_wait_inc = r_wait + 8'd1;
  assign w_timeout  = (w_wait_inc == WAIT_LIMIT);

  // Next-PC candidates; jump takes priority over a taken branch.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_branch_tgt = w_pc_plus4 + w_branch_off;
  assign w_jump_tgt   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

  // Select the PC that follows the instruction currently in ISSUE.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (jump) begin
      w_pc_next = w_jump_tgt;
    end else if (branch && zero) begin
      w_pc_next = w_branch_tgt;
    end
  end

  // Sequencer next-state and datapath load enables.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_instr = 1'b0;
    w_load_pc    = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_step  = 1'b0;
    w_set_fault  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wait_clr  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A response on the limit cycle still counts as a successful fetch.
        if (imemValid) begin
          w_load_instr = 1'b1;
          w_wait_clr   = 1'b1;
          w_state_nxt  = S_ISSUE;
        end else begin
          w_wait_step = 1'b1;
          if (w_timeout) begin
            w_set_fault = 1'b1;
            w_state_nxt = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          w_load_pc   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter: advances only when the issued instruction is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_INIT;
    end else if (w_load_pc) begin
      r_pc <= {w_pc_next[31:2], 2'b00};
    end
  end

  // Instruction latch: captured on the FETCH to ISSUE transition only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= 32'd0;
    end else if (w_load_instr) begin
      r_instr <= imemData;
    end
  end

  // Consecutive wait-cycle counter for the current fetch.
  always_ff @(posedge clk) begin
    if (rst || w_wait_clr) begin
      r_wait <= 8'd0;
    end else if (w_wait_step) begin
      r_wait <= w_wait_inc;
    end
  end

  // Sticky fault flag; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_set_fault) begin
      r_fault <= 1'b1;
    end
  end

  assign imemReq    = (r_state == S_FETCH);
  assign imemAddr   = r_pc;
  assign instrValid = (r_state == S_ISSUE);
  assign instr      = r_instr;
  assign opCode     = r_instr[31:26];
  assign pc         = r_pc;
  assign fault      = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a behavioural model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0003;
  localparam int          MAXW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic        instrValid;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        hold;
  logic [31:0] pc;
  logic        fault;

  fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData),
    .instr(instr), .opCode(opCode), .instrValid(instrValid),
    .branch(branch), .jump(jump), .zero(zero), .hold(hold),
    .pc(pc), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 waiting one cycle after reset, 1 requesting memory, 2 presenting, 3 stopped on timeout.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;
  int          m_waits;
  bit          m_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                          input bit j, input bit b, input bit z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b && z) return seq + 32'(off);
    return seq;
  endfunction

  // Advance the model across one rising edge given the inputs held during that cycle.
  task automatic model_edge(input bit r, input bit v, input logic [31:0] d,
                            input bit b, input bit j, input bit z, input bit h);
    if (r) begin
      m_mode = 0; m_pc = RST_PC & ~32'd3; m_instr = 0; m_fault = 0; m_waits = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_waits = 0;
    end else if (m_mode == 1) begin
      if (v) begin
        m_instr = d; m_waits = 0; m_mode = 2;
      end else begin
        m_waits++;
        if (m_waits == MAXW) begin m_fault = 1; m_mode = 3; end
      end
    end else if (m_mode == 2) begin
      if (!h) begin m_pc = next_pc(m_pc, m_instr, j, b, z); m_mode = 1; end
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("imemReq",    {31'd0, imemReq},    {31'd0, m_mode == 1});
      chk("imemAddr",   imemAddr,            m_pc);
      chk("instrValid", {31'd0, instrValid}, {31'd0, m_mode == 2});
      chk("instr",      instr,               m_instr);
      chk("opCode",     {26'd0, opCode},     {26'd0, m_instr[31:26]});
      chk("pc",         pc,                  m_pc);
      chk("fault",      {31'd0, fault},      {31'd0, m_fault});
    end
  end

  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input bit b, input bit j, input bit z, input bit h);
    @(negedge clk);
    #1;
    rst = r; imemValid = v; imemData = d; branch = b; jump = j; zero = z; hold = h;
    model_edge(r, v, d, b, j, z, h);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; imemValid = 0; imemData = 0; branch = 0; jump = 0; zero = 0; hold = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    m_on = 1'b1;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Reset fetch with zero-wait memory
    step(0, 0, 0, 0, 0, 0, 0);
    chk("first_req", {31'd0, imemReq}, 32'd1);
    chk("first_addr", imemAddr, 32'h0040_0000);
    step(0, 1, 32'h8C08_0004, 0, 0, 0, 0);
    chk("first_valid", {31'd0, instrValid}, 32'd1);
    chk("first_opcode", {26'd0, opCode}, 32'h23);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_addr", imemAddr, 32'h0040_0004);

    // Jump to 0x100 to set up the branch case
    step(0, 1, 32'h0800_0040, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("jump_0x100", pc, 32'h0000_0100);

    // Branch taken back to itself, then not taken
    step(0, 1, 32'h1000_FFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    chk("branch_taken", pc, 32'h0000_0100);
    step(0, 1, 32'h1000_FFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("branch_not_taken", pc, 32'h0000_0104);

    // Move to 0x0040_0010 and check jump priority over branch
    step(0, 1, 32'h0810_0004, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("jump_0x400010", pc, 32'h0040_0010);
    step(0, 1, 32'h0810_0000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    chk("jump_priority", pc, 32'h0040_0000);

    // Three wait states then valid on the limit cycle, then hold for two cycles
    idle_n(3);
    chk("wait_addr", imemAddr, 32'h0040_0000);
    chk("wait_req", {31'd0, imemReq}, 32'd1);
    step(0, 1, 32'h2001_0005, 0, 0, 0, 0);
    chk("limit_valid_issue", {31'd0, instrValid}, 32'd1);
    chk("limit_valid_nofault", {31'd0, fault}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("hold_pc", pc, 32'h0040_0000);
    chk("hold_valid", {31'd0, instrValid}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("release_pc", pc, 32'h0040_0004);

    // Timeout after four empty FETCH cycles
    idle_n(4);
    chk("timeout_fault", {31'd0, fault}, 32'd1);
    chk("timeout_req", {31'd0, imemReq}, 32'd0);
    step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("halt_ignores_valid", instr, 32'h2001_0005);
    chk("halt_fault_sticky", {31'd0, fault}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_clears_fault", {31'd0, fault}, 32'd0);
    chk("rst_restart_pc", pc, 32'h0040_0000);

    // Reset while held in ISSUE
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8C08_0004, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_valid", {31'd0, instrValid}, 32'd0);
    chk("mid_rst_opcode", {26'd0, opCode}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0040_0000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("resume_req", {31'd0, imemReq}, 32'd1);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = (m_mode == 3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      step(r, $urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
           $urandom_range(0, 1), $urandom_range(0, 9) < 3);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing block for the MIPS datapath. It is the producer side of the control-unit interface: it issues fetches to instruction memory, presents each fetched word and its `opCode` field to the control unit, and consumes the returned `branch`/`jump` decisions plus the ALU `zero` flag to compute the next PC. The memory side uses a level request / valid handshake with variable latency and a wait-state timeout.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] are ignored and treated as 0.
- `MAX_WAIT`, default 15 (range 1..255): number of FETCH cycles without `imemValid` before a fault is raised.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imemReq`  out  1  fetch request; high only in FETCH.
- `imemAddr`  out  32  fetch address; equals `pc` and is stable while `imemReq` is high.
- `imemValid`  in  1  memory returns data this cycle; sampled only in FETCH.
- `imemData`  in  32  instruction word; sampled when `imemValid` is high in FETCH.
- `instr`  out  32  latched instruction.
- `opCode`  out  6  `instr[31:26]`, drives the control unit.
- `instrValid`  out  1  high throughout ISSUE.
- `branch`, `jump`  in  1 each  control-unit decode of `opCode`; sampled in ISSUE.
- `zero`  in  1  ALU zero flag; sampled in ISSUE.
- `hold`  in  1  datapath stall; keeps the block in ISSUE.
- `pc`  out  32  current PC.
- `fault`  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, ISSUE, HALT. Reset state is IDLE.
- IDLE: always moves to FETCH on the next cycle. The wait counter clears.
- FETCH:
  - `imemReq`=1.
  - If `imemValid`=1: latch `imemData` into `instr`, clear the wait counter, go to ISSUE.
  - Otherwise the wait counter increments. When it reaches `MAX_WAIT`, set `fault`=1 and go to HALT.
  - If `imemValid` arrives in the same cycle the counter reaches the limit, `imemValid` wins and no fault is raised.
- ISSUE:
  - `instrValid`=1.
  - If `hold`=1: stay in ISSUE; `pc` and `instr` are unchanged.
  - Otherwise: load `pc` with next-PC and go to FETCH.
- HALT: `imemReq`=0 and `instrValid`=0. `imemValid` is ignored. Only `rst` exits HALT.
- Next-PC calculation, all arithmetic modulo 2^32:
  - pcPlus4 = `pc` + 4.
  - If `jump`: {pcPlus4[31:28], `instr`[25:0], 2'b00}.
  - Else if `branch` & `zero`: pcPlus4 + (sign-extended `instr`[15:0] << 2).
  - Else: pcPlus4.
  - `jump` has priority over `branch` when both are asserted.
  - `pc`[1:0] is always 0.
- `imemValid` outside FETCH is ignored and causes no state change.

## Timing
- Reset values, in the cycle after a `rst` edge:
  - state = IDLE, `pc` = `RESET_PC` & ~3, `instr` = 0, `opCode` = 0.
  - `imemReq` = 0, `instrValid` = 0, `fault` = 0, wait counter = 0.
- Reset mid-operation, in any state including HALT: the same values apply on the next edge. Any fetch in flight is abandoned.
- The first `imemReq` is asserted 2 cycles after the first edge with `rst` low (one cycle in IDLE, then FETCH).
- Zero-wait memory (`imemValid` in the first FETCH cycle): 2 cycles per instruction (1 FETCH + 1 ISSUE).
  - Each additional wait cycle adds 1 cycle.
  - Each cycle of `hold` adds 1 cycle.
- `opCode` and `instr` change only on the FETCH→ISSUE edge.
- `branch`, `jump` and `zero` are combinational from the datapath. They must be valid in the ISSUE cycle in which `hold`=0.
- `fault` rises on the edge that ends the `MAX_WAIT`-th consecutive FETCH cycle without `imemValid`. `imemReq` is low from that edge onward.

## Test plan
- **Reset fetch.** Set `RESET_PC`=0x0040_0000; memory returns 0x8C08_0004 with zero wait.
  - `imemAddr`=0x0040_0000.
  - Next cycle: `instrValid`=1, `opCode`=6'h23.
  - Then `imemAddr`=0x0040_0004.
  - Fetches repeat every 2 cycles.
- **Branch.** `pc`=0x100, instr 0x1000_FFFF.
  - With `branch`=1, `zero`=1: next `pc`=0x100.
  - Repeat with `zero`=0: next `pc`=0x104.
- **Jump priority.** `pc`=0x0040_0010, instr 0x0810_0000, with `jump`=1, `branch`=1, `zero`=1 → next `pc`=0x0040_0000.
- **Wait states and hold.** `imemValid` arrives 3 cycles after `imemReq`, then `hold`=1 for 2 cycles.
  - `imemAddr` is stable for 4 cycles.
  - `instrValid` is high for 3 cycles.
  - `pc` is unchanged until `hold` drops.
- **Timeout.** `MAX_WAIT`=4 and `imemValid` is never asserted.
  - `fault`=1 and `imemReq`=0 after 4 FETCH cycles.
  - A later `imemValid` has no effect.
  - `rst` clears `fault` and restarts fetch at `RESET_PC`.
  - Variant: `imemValid` in the 4th cycle → ISSUE, with no fault.
- **Reset mid-ISSUE.** `rst` asserted during ISSUE with `hold`=1.
  - Next cycle: `instrValid`=0, `pc`=`RESET_PC`, `opCode`=0.
  - Fetch resumes 2 cycles after `rst` deasserts.
